// File: rtl/snake_pkg.sv
// Shared definitions for the snake engine and its game controller.
// Cell classes, board geometry, start layout, directions, LFSR seed.
package snake_pkg;

  localparam int BOARD_W = 16;
  localparam int BOARD_H = 16;
  localparam int CELLS   = BOARD_W * BOARD_H;
  localparam int MAX_LEN = 64;
  localparam int PTR_W   = 6;
  localparam int LEN_W   = 7;

  localparam logic [7:0] LFSR_SEED = 8'h5A;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_BODY  = 2'b01,
    CELL_APPLE = 2'b10,
    CELL_WALL  = 2'b11
  } cell_e;

  // Right is encoded as zero so a cleared register means "right".
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_UP    = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] x;
  } coord_t;

  localparam coord_t START_HEAD  = '{y: 4'd8, x: 4'd8};
  localparam coord_t START_MID   = '{y: 4'd8, x: 4'd7};
  localparam coord_t START_TAIL  = '{y: 4'd8, x: 4'd6};
  localparam coord_t START_APPLE = '{y: 4'd8, x: 4'd12};
  localparam logic [LEN_W-1:0] START_LEN = 7'd3;

  function automatic logic is_wall(coord_t c);
    return (c.x == 4'd0) || (c.x == 4'd15) ||
           (c.y == 4'd0) || (c.y == 4'd15);
  endfunction

  function automatic coord_t step_coord(coord_t c, dir_e d);
    coord_t n;
    n = c;
    unique case (d)
      DIR_UP:    n.y = c.y - 4'd1;
      DIR_DOWN:  n.y = c.y + 4'd1;
      DIR_LEFT:  n.x = c.x - 4'd1;
      DIR_RIGHT: n.x = c.x + 4'd1;
    endcase
    return n;
  endfunction

  function automatic logic is_reverse(dir_e a, dir_e b);
    return (a == DIR_UP    && b == DIR_DOWN) ||
           (a == DIR_DOWN  && b == DIR_UP)   ||
           (a == DIR_LEFT  && b == DIR_RIGHT) ||
           (a == DIR_RIGHT && b == DIR_LEFT);
  endfunction

endpackage

// File: rtl/snake_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
// Ports: clk2, rst_n (sync, active low), value (current state).
module snake_lfsr
  import snake_pkg::*;
(
  input  logic       clk2,
  input  logic       rst_n,
  output logic [7:0] value
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0],
              lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk2) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/snake_engine.sv
// Snake body/apple state machine: circular body buffer, occupancy map,
// direction latch, score and apple relocation search.
// Ports: clk2, rst_n (sync, active low); phase strobes menu, first_do,
//   go_one_step, eat_apple, random_growth, null_out, game_over;
//   dir_btn[3:0] {right,left,down,up}; head = class of next cell;
//   qx/qy -> q_class display query; score; apple_busy.
module snake_engine
  import snake_pkg::*;
(
  input  logic       clk2,
  input  logic       rst_n,
  input  logic       menu,
  input  logic       first_do,
  input  logic       go_one_step,
  input  logic       eat_apple,
  input  logic       random_growth,
  input  logic       null_out,
  input  logic       game_over,
  input  logic [3:0] dir_btn,
  output logic [1:0] head,
  input  logic [3:0] qx,
  input  logic [3:0] qy,
  output logic [1:0] q_class,
  output logic [7:0] score,
  output logic       apple_busy
);

  coord_t             body_q [MAX_LEN];
  coord_t             body_d [MAX_LEN];
  logic [PTR_W-1:0]   hd_ptr_q, hd_ptr_d;
  logic [PTR_W-1:0]   tl_ptr_q, tl_ptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CELLS-1:0]   occ_q, occ_d;
  coord_t             apple_q, apple_d;
  dir_e               dir_q, dir_d;
  logic [7:0]         score_q, score_d;
  logic               busy_q, busy_d;

  logic [7:0]         lfsr_val;
  coord_t             cand;
  coord_t             head_pos;
  coord_t             target;
  coord_t             query;
  dir_e               btn_dir;
  logic               btn_ok;
  logic               push;
  logic               pop;
  logic               rg_start;

  // The decision phase needs nothing from the engine.
  logic               unused_go;
  assign unused_go = go_one_step;

  snake_lfsr u_lfsr (
    .clk2  (clk2),
    .rst_n (rst_n),
    .value (lfsr_val)
  );

  function automatic cell_e classify(
    coord_t           c,
    logic [CELLS-1:0] occ,
    coord_t           apple
  );
    if (is_wall(c)) return CELL_WALL;
    if (occ[c]) return CELL_BODY;
    if (c == apple) return CELL_APPLE;
    return CELL_EMPTY;
  endfunction

  assign head_pos = body_q[hd_ptr_q];
  assign target   = step_coord(head_pos, dir_q);
  assign query    = '{y: qy, x: qx};
  assign cand     = coord_t'(lfsr_val);

  assign head       = classify(target, occ_q, apple_q);
  assign q_class    = classify(query, occ_q, apple_q);
  assign score      = score_q;
  assign apple_busy = busy_q;

  always_comb begin
    btn_dir = DIR_RIGHT;
    if ($onehot(dir_btn)) begin
      unique case (1'b1)
        dir_btn[0]: btn_dir = DIR_UP;
        dir_btn[1]: btn_dir = DIR_DOWN;
        dir_btn[2]: btn_dir = DIR_LEFT;
        dir_btn[3]: btn_dir = DIR_RIGHT;
      endcase
    end
  end

  assign btn_ok = $onehot(dir_btn) && !menu && !game_over &&
                  !is_reverse(dir_q, btn_dir);

  always_comb begin
    body_d   = body_q;
    hd_ptr_d = hd_ptr_q;
    tl_ptr_d = tl_ptr_q;
    len_d    = len_q;
    occ_d    = occ_q;
    apple_d  = apple_q;
    dir_d    = dir_q;
    score_d  = score_q;
    busy_d   = busy_q;
    push     = 1'b0;
    pop      = 1'b0;
    rg_start = 1'b0;

    if (first_do) begin
      body_d[0] = START_TAIL;
      body_d[1] = START_MID;
      body_d[2] = START_HEAD;
      hd_ptr_d  = 6'd2;
      tl_ptr_d  = 6'd0;
      len_d     = START_LEN;
      occ_d     = '0;
      occ_d[START_TAIL] = 1'b1;
      occ_d[START_MID]  = 1'b1;
      occ_d[START_HEAD] = 1'b1;
      dir_d     = DIR_RIGHT;
      apple_d   = START_APPLE;
      score_d   = 8'd0;
      busy_d    = 1'b0;
    end else begin
      if (btn_ok) dir_d = btn_dir;

      // A full-length snake eating keeps its length: it pops too.
      if (eat_apple) begin
        push = 1'b1;
        pop  = (len_q == LEN_W'(MAX_LEN));
        if (len_q != LEN_W'(MAX_LEN)) len_d = len_q + 7'd1;
        if (score_q != 8'hFF) score_d = score_q + 8'd1;
      end else if (null_out) begin
        push = 1'b1;
        pop  = 1'b1;
      end else if (random_growth) begin
        rg_start = 1'b1;
      end

      // Clear the old tail before marking the new head, so a head
      // moving into the cell the tail just left stays marked.
      if (pop) begin
        occ_d[body_q[tl_ptr_q]] = 1'b0;
        tl_ptr_d = tl_ptr_q + 6'd1;
      end
      if (push) begin
        hd_ptr_d = hd_ptr_q + 6'd1;
        body_d[hd_ptr_d] = target;
        occ_d[target] = 1'b1;
      end

      if (rg_start) begin
        busy_d = 1'b1;
      end else if (busy_q && !is_wall(cand) && !occ_d[cand]) begin
        apple_d = cand;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk2) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) body_q[i] <= '0;
      hd_ptr_q <= '0;
      tl_ptr_q <= '0;
      len_q    <= '0;
      occ_q    <= '0;
      apple_q  <= '0;
      dir_q    <= DIR_RIGHT;
      score_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      body_q   <= body_d;
      hd_ptr_q <= hd_ptr_d;
      tl_ptr_q <= tl_ptr_d;
      len_q    <= len_d;
      occ_q    <= occ_d;
      apple_q  <= apple_d;
      dir_q    <= dir_d;
      score_q  <= score_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: vector table plus
// model-driven sequences feeding a scoreboard queue.
module tb_snake_engine;

  logic       clk2 = 1'b0;
  logic       rst_n;
  logic       menu, first_do, go_one_step, eat_apple;
  logic       random_growth, null_out, game_over;
  logic [3:0] dir_btn;
  logic [1:0] head;
  logic [3:0] qx, qy;
  logic [1:0] q_class;
  logic [7:0] score;
  logic       apple_busy;

  snake_engine dut (
    .clk2          (clk2),
    .rst_n         (rst_n),
    .menu          (menu),
    .first_do      (first_do),
    .go_one_step   (go_one_step),
    .eat_apple     (eat_apple),
    .random_growth (random_growth),
    .null_out      (null_out),
    .game_over     (game_over),
    .dir_btn       (dir_btn),
    .head          (head),
    .qx            (qx),
    .qy            (qy),
    .q_class       (q_class),
    .score         (score),
    .apple_busy    (apple_busy)
  );

  always #5 clk2 = ~clk2;

  localparam logic [6:0] S_NONE = 7'h00;
  localparam logic [6:0] S_FD   = 7'h40;
  localparam logic [6:0] S_EAT  = 7'h20;
  localparam logic [6:0] S_NULL = 7'h10;
  localparam logic [6:0] S_RG   = 7'h08;
  localparam logic [6:0] S_GO   = 7'h04;
  localparam logic [6:0] S_MENU = 7'h02;
  localparam logic [6:0] S_GOV  = 7'h01;
  localparam logic [3:0] B_UP = 4'b0001;
  localparam logic [3:0] B_DN = 4'b0010;
  localparam logic [3:0] B_LT = 4'b0100;
  localparam logic [3:0] B_RT = 4'b1000;

  typedef struct {
    string      name;
    logic [1:0] head;
    logic [1:0] q;
    logic [7:0] score;
    logic       busy;
  } exp_t;

  typedef struct {
    logic [6:0] s;
    logic [3:0] d;
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] head;
    logic [1:0] q;
    logic [7:0] score;
  } vec_t;

  exp_t sb[$];
  vec_t tv[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model: queue front = tail, back = head
  logic [7:0] mbody[$];
  logic [7:0] mapple;
  int         mdir;
  int         mscore;

  task automatic cmp(input string n, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic check_one();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: empty queue");
    end else begin
      e = sb.pop_front();
      cmp({e.name, "/head"}, int'(head), int'(e.head));
      cmp({e.name, "/q"}, int'(q_class), int'(e.q));
      cmp({e.name, "/score"}, int'(score), int'(e.score));
      cmp({e.name, "/busy"}, int'(apple_busy), int'(e.busy));
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] d,
                       input logic [3:0] x, input logic [3:0] y,
                       input exp_t e);
    @(negedge clk2);
    {first_do, eat_apple, null_out, random_growth,
     go_one_step, menu, game_over} = s;
    dir_btn = d;
    qx = x;
    qy = y;
    sb.push_back(e);
    @(posedge clk2);
    #1;
    {first_do, eat_apple, null_out, random_growth,
     go_one_step, menu, game_over} = '0;
    dir_btn = '0;
    check_one();
  endtask

  function automatic logic [7:0] mtarget();
    logic [7:0] h;
    logic [3:0] x, y;
    h = (mbody.size() == 0) ? 8'h00 : mbody[mbody.size()-1];
    x = h[3:0];
    y = h[7:4];
    case (mdir)
      0: y = y - 4'd1;
      1: y = y + 4'd1;
      2: x = x - 4'd1;
      default: x = x + 4'd1;
    endcase
    return {y, x};
  endfunction

  function automatic logic [1:0] mclass(logic [7:0] c);
    if (c[3:0] == 4'd0 || c[3:0] == 4'd15 ||
        c[7:4] == 4'd0 || c[7:4] == 4'd15) return 2'b11;
    foreach (mbody[i]) if (mbody[i] == c) return 2'b01;
    if (c == mapple) return 2'b10;
    return 2'b00;
  endfunction

  task automatic mreset();
    mbody.delete();
    mapple = 8'h00;
    mdir = 3;
    mscore = 0;
  endtask

  task automatic mstep(input logic [6:0] s, input logic [3:0] db);
    logic [7:0] t;
    int nd;
    t = mtarget();
    if (s[6]) begin
      mbody = '{8'h86, 8'h87, 8'h88};
      mdir = 3;
      mapple = 8'h8C;
      mscore = 0;
    end else begin
      if (s[5]) begin
        mbody.push_back(t);
        if (mbody.size() > 64) void'(mbody.pop_front());
        if (mscore < 255) mscore++;
      end else if (s[4]) begin
        mbody.push_back(t);
        void'(mbody.pop_front());
      end
      case (db)
        4'b0001: nd = 0;
        4'b0010: nd = 1;
        4'b0100: nd = 2;
        4'b1000: nd = 3;
        default: nd = -1;
      endcase
      if (!s[1] && !s[0] && nd >= 0 && nd != (mdir ^ 1)) mdir = nd;
    end
  endtask

  task automatic mdrive(input logic [6:0] s, input logic [3:0] d,
                        input logic [3:0] x, input logic [3:0] y,
                        input logic tailq, input string n);
    exp_t e;
    logic [7:0] c;
    mstep(s, d);
    c = tailq ? mbody[0] : {y, x};
    e.name = n;
    e.head = mclass(mtarget());
    e.q = mclass(c);
    e.score = 8'(mscore);
    e.busy = s[3] & ~s[6] & ~s[5] & ~s[4];
    drive(s, d, c[3:0], c[7:4], e);
  endtask

  task automatic add(input logic [6:0] s, input logic [3:0] d,
                     input logic [3:0] x, input logic [3:0] y,
                     input logic [1:0] h, input logic [1:0] q,
                     input logic [7:0] sc);
    vec_t v;
    v = '{s, d, x, y, h, q, sc};
    tv.push_back(v);
  endtask

  initial begin
    exp_t e;
    logic [7:0] h;
    logic [7:0] found;
    int eats, napple, inbody;
    logic moved_dn;

    rst_n = 1'b0;
    {first_do, eat_apple, null_out, random_growth,
     go_one_step, menu, game_over} = '0;
    dir_btn = '0;
    qx = '0;
    qy = '0;
    mreset();
    repeat (2) @(posedge clk2);
    @(negedge clk2);
    rst_n = 1'b1;

    // s, btn, qx, qy, head, q_class, score
    add(S_NONE, 4'd0,  8, 8, 2'd3, 2'd0, 0);
    add(S_NONE, 4'd0,  0, 0, 2'd3, 2'd3, 0);
    add(S_FD,   4'd0, 12, 8, 2'd0, 2'd2, 0);
    add(S_NONE, 4'd0,  8, 8, 2'd0, 2'd1, 0);
    add(S_NONE, 4'd0,  6, 8, 2'd0, 2'd1, 0);
    add(S_NONE, 4'd0,  5, 8, 2'd0, 2'd0, 0);
    add(S_NULL, 4'd0,  6, 8, 2'd0, 2'd0, 0);
    add(S_NULL, 4'd0,  7, 8, 2'd0, 2'd0, 0);
    add(S_NULL, 4'd0,  9, 8, 2'd2, 2'd1, 0);
    add(S_EAT,  4'd0,  9, 8, 2'd0, 2'd1, 1);
    add(S_NONE, B_LT, 12, 8, 2'd0, 2'd1, 1);
    add(S_NONE, B_UP, 12, 7, 2'd0, 2'd0, 1);
    add(S_NULL, 4'b0011, 12, 7, 2'd0, 2'd1, 1);
    add(S_NONE, B_DN, 10, 8, 2'd0, 2'd1, 1);
    add(S_GO,   4'd0, 10, 8, 2'd0, 2'd1, 1);
    add(S_NULL, 4'd0, 10, 8, 2'd0, 2'd0, 1);
    add(S_NULL, 4'd0, 11, 8, 2'd0, 2'd0, 1);
    add(S_NULL, 4'd0, 12, 8, 2'd0, 2'd2, 1);
    add(S_NULL, 4'd0, 12, 4, 2'd0, 2'd1, 1);
    add(S_NULL, 4'd0, 12, 3, 2'd0, 2'd1, 1);
    add(S_NULL, 4'd0, 12, 1, 2'd3, 2'd1, 1);
    add(S_GOV,  B_LT, 12, 0, 2'd3, 2'd3, 1);
    add(S_MENU, B_LT, 12, 0, 2'd3, 2'd3, 1);
    add(S_NONE, B_LT, 11, 1, 2'd0, 2'd0, 1);
    add(S_NONE, B_RT, 11, 1, 2'd0, 2'd0, 1);
    add(S_NULL, 4'd0, 11, 1, 2'd0, 2'd1, 1);

    foreach (tv[i]) begin
      e.name = $sformatf("vec%0d", i);
      e.head = tv[i].head;
      e.q = tv[i].q;
      e.score = tv[i].score;
      e.busy = 1'b0;
      drive(tv[i].s, tv[i].d, tv[i].x, tv[i].y, e);
    end

    // body against the left wall at (1,8), heading left
    mdrive(S_FD, 0, 8, 8, 0, "wl_fd");
    mdrive(S_NONE, B_UP, 8, 7, 0, "wl_up");
    mdrive(S_NULL, 0, 8, 7, 0, "wl_mv");
    mdrive(S_NONE, B_LT, 8, 7, 0, "wl_lt");
    for (int i = 0; i < 7; i++)
      mdrive(S_NULL, 0, 0, 0, 1, $sformatf("wl_mv%0d", i));
    mdrive(S_NONE, B_DN, 1, 7, 0, "wl_dn");
    mdrive(S_NULL, 0, 1, 8, 0, "wl_mv_dn");
    mdrive(S_NONE, B_LT, 1, 8, 0, "wl_wall");
    cmp("wl_head_wall", int'(head), 3);

    // coiled 2x2: target is the tail cell
    mdrive(S_FD, 0, 0, 0, 1, "co_fd");
    mdrive(S_EAT, 0, 0, 0, 1, "co_eat");
    mdrive(S_NONE, B_UP, 0, 0, 1, "co_up");
    mdrive(S_NULL, 0, 0, 0, 1, "co_mv1");
    mdrive(S_NONE, B_LT, 0, 0, 1, "co_lt");
    mdrive(S_NULL, 0, 0, 0, 1, "co_mv2");
    mdrive(S_NONE, B_DN, 8, 8, 0, "co_dn");
    cmp("co_head_tail", int'(head), 1);

    // eat and null together: growth wins
    mdrive(S_FD, 0, 0, 0, 1, "en_fd");
    mdrive(S_EAT | S_NULL, 0, 6, 8, 0, "en_both");

    // apple relocation search
    mdrive(S_FD, 0, 12, 8, 0, "rg_fd");
    mdrive(S_RG | S_GO, 0, 8, 8, 0, "rg_start");
    for (int i = 0; i < 600; i++) begin
      if (!apple_busy) break;
      @(posedge clk2);
      #1;
    end
    cmp("rg_done", int'(apple_busy), 0);
    napple = 0;
    found = 8'h00;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        qx = 4'(x);
        qy = 4'(y);
        #1;
        if (q_class == 2'b10) begin
          napple++;
          found = {4'(y), 4'(x)};
        end
      end
    end
    cmp("rg_apple_count", napple, 1);
    cmp("rg_interior",
        int'(found[3:0] != 0 && found[3:0] != 15 &&
             found[7:4] != 0 && found[7:4] != 15), 1);
    inbody = 0;
    foreach (mbody[i]) if (mbody[i] == found) inbody = 1;
    cmp("rg_not_body", inbody, 0);
    mapple = found;
    mdrive(S_NONE, 0, found[3:0], found[7:4], 0, "rg_after");

    // 64 apples along a serpentine path
    mdrive(S_FD, 0, 0, 0, 1, "sn_fd");
    eats = 0;
    moved_dn = 1'b0;
    for (int k = 0; k < 200 && eats < 64; k++) begin
      h = mbody[mbody.size()-1];
      if (mdir == 1 && moved_dn) begin
        mdrive(S_NONE, (h[3:0] == 4'd14) ? B_LT : B_RT,
               0, 0, 1, "sn_turn_h");
        moved_dn = 1'b0;
      end else if ((mdir == 3 && h[3:0] == 4'd14) ||
                   (mdir == 2 && h[3:0] == 4'd1)) begin
        mdrive(S_NONE, B_DN, 0, 0, 1, "sn_turn_d");
      end else begin
        if (mdir == 1) moved_dn = 1'b1;
        mdrive(S_EAT, 0, 0, 0, 1, $sformatf("sn_eat%0d", eats));
        eats++;
      end
    end
    cmp("sn_len", int'(dut.len_q), 64);
    mdrive(S_NONE, 0, 8, 8, 0, "sn_old_tail");
    for (int i = 0; i < 4; i++)
      mdrive(S_NULL, 0, 0, 0, 1, $sformatf("sn_null%0d", i));

    // reset while the apple search is running
    mdrive(S_FD, 0, 8, 8, 0, "rs_fd");
    mdrive(S_EAT, 0, 8, 8, 0, "rs_eat");
    mdrive(S_RG, 0, 8, 8, 0, "rs_rg");
    @(negedge clk2);
    rst_n = 1'b0;
    @(posedge clk2);
    #1;
    cmp("rs_busy", int'(apple_busy), 0);
    cmp("rs_score", int'(score), 0);
    cmp("rs_head", int'(head), 3);
    cmp("rs_q", int'(q_class), 0);
    cmp("rs_len", int'(dut.len_q), 0);
    @(negedge clk2);
    rst_n = 1'b1;
    mreset();
    mdrive(S_NONE, 0, 8, 8, 0, "rs_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
